// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Purpose:
//   Shares one single-port on-chip RAM between two Avalon-MM pipelined masters
//   (m0 = Nios II data port, m1 = DMA/streaming engine). Round-robin grant,
//   fixed 1-cycle read latency, out-of-range detection with a sticky flag.
//
// Configuration macro:
//   ONCHIP_MEM_ARB_LOCK_EN - adds m0_lock/m1_lock. An access accepted with
//   lock=1 pins the grant to that master until its lock is seen low.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   mN_address/byteenable/read/write/writedata   master N command inputs
//   mN_waitrequest                   1 = request not accepted this cycle
//   mN_readdata/mN_readdatavalid     read return (data forced 0 when not valid)
//   mem_address/byteenable/chipselect/write/writedata/clken   RAM controls
//   mem_readdata                     RAM output, valid 1 cycle after a read
//   err_oor                          sticky out-of-range flag
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 25000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
`ifdef ONCHIP_MEM_ARB_LOCK_EN
    input  logic                  m0_lock,
    input  logic                  m1_lock,
`endif
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  err_oor
);
    localparam int                BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W + 1)'(DEPTH);

    // Master-side signals gathered into index-able form
    logic [1:0]              w_rd_in, w_wr_in, w_req, w_elig, w_cand;
    logic [ADDR_W-1:0]       w_addr  [2];
    logic [BE_W-1:0]         w_be    [2];
    logic [DATA_W-1:0]       w_wdata [2];

    assign w_rd_in    = {m1_read, m0_read};
    assign w_wr_in    = {m1_write, m0_write};
    assign w_addr[0]  = m0_address;
    assign w_addr[1]  = m1_address;
    assign w_be[0]    = m0_byteenable;
    assign w_be[1]    = m1_byteenable;
    assign w_wdata[0] = m0_writedata;
    assign w_wdata[1] = m1_writedata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_req[gi] = w_rd_in[gi] | w_wr_in[gi];
        end
    endgenerate

    // State
    logic                r_last_grant;   // 1 = master 1 served last
    logic                r_pending;      // read accepted last cycle
    logic                r_owner;        // which master owns that read
    logic                r_rd_oor;       // that read was out of range
    logic                r_err_oor;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic [BE_W-1:0]     r_be_hold;
    logic [DATA_W-1:0]   r_wdata_hold;

`ifdef ONCHIP_MEM_ARB_LOCK_EN
    logic [1:0] w_lock;
    logic       r_pinned;
    logic       r_pin_owner;
    assign w_lock = {m1_lock, m0_lock};
    // While pinned only the owner may be granted, even if it is idle.
    assign w_elig = r_pinned ? (r_pin_owner ? 2'b10 : 2'b01) : 2'b11;
`else
    assign w_elig = 2'b11;
`endif

    assign w_cand = w_req & w_elig;

    // Grant decision
    logic w_grant_valid;
    logic w_grant_idx;
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 1'b0;
        if (!reset) begin
            case (w_cand)
                2'b01:   begin w_grant_valid = 1'b1; w_grant_idx = 1'b0;          end
                2'b10:   begin w_grant_valid = 1'b1; w_grant_idx = 1'b1;          end
                2'b11:   begin w_grant_valid = 1'b1; w_grant_idx = ~r_last_grant; end
                default: begin w_grant_valid = 1'b0; w_grant_idx = 1'b0;          end
            endcase
        end
    end

    logic [ADDR_W-1:0] w_sel_addr;
    logic [BE_W-1:0]   w_sel_be;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_wr;
    logic              w_oor;

    assign w_sel_addr  = w_addr[w_grant_idx];
    assign w_sel_be    = w_be[w_grant_idx];
    assign w_sel_wdata = w_wdata[w_grant_idx];
    // Read+write together counts as a write
    assign w_sel_wr    = w_wr_in[w_grant_idx];
    assign w_oor       = ({1'b0, w_sel_addr} >= C_DEPTH);

    assign m0_waitrequest = ~(w_grant_valid & ~w_grant_idx);
    assign m1_waitrequest = ~(w_grant_valid &  w_grant_idx);

    // Out-of-range accesses are accepted but never reach the RAM
    assign mem_chipselect = w_grant_valid & ~w_oor;
    assign mem_write      = w_grant_valid & ~w_oor & w_sel_wr;
    assign mem_clken      = ~reset;
    assign mem_address    = reset ? '0 : (w_grant_valid ? w_sel_addr  : r_addr_hold);
    assign mem_byteenable = reset ? '0 : (w_grant_valid ? w_sel_be    : r_be_hold);
    assign mem_writedata  = reset ? '0 : (w_grant_valid ? w_sel_wdata : r_wdata_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_pending    <= 1'b0;
            r_owner      <= 1'b0;
            r_rd_oor     <= 1'b0;
            r_err_oor    <= 1'b0;
            r_addr_hold  <= '0;
            r_be_hold    <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_pending <= w_grant_valid & ~w_sel_wr;
            r_owner   <= w_grant_idx;
            r_rd_oor  <= w_oor;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
                r_addr_hold  <= w_sel_addr;
                r_be_hold    <= w_sel_be;
                r_wdata_hold <= w_sel_wdata;
                if (w_oor) begin
                    r_err_oor <= 1'b1;
                end
            end
        end
    end

`ifdef ONCHIP_MEM_ARB_LOCK_EN
    // Release takes effect the cycle after the owner drops lock
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pinned    <= 1'b0;
            r_pin_owner <= 1'b0;
        end else if (w_grant_valid && w_lock[w_grant_idx]) begin
            r_pinned    <= 1'b1;
            r_pin_owner <= w_grant_idx;
        end else if (r_pinned && !w_lock[r_pin_owner]) begin
            r_pinned    <= 1'b0;
        end
    end
`endif

    // Read return; suppressed during reset so an in-flight read is dropped
    logic [DATA_W-1:0] w_rdata;
    assign w_rdata          = r_rd_oor ? '0 : mem_readdata;
    assign m0_readdatavalid = r_pending & ~r_owner & ~reset;
    assign m1_readdatavalid = r_pending &  r_owner & ~reset;
    assign m0_readdata      = m0_readdatavalid ? w_rdata : '0;
    assign m1_readdata      = m1_readdatavalid ? w_rdata : '0;
    assign err_oor          = r_err_oor & ~reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 25000;

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
    logic [3:0]        m0_byteenable, m1_byteenable, mem_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [31:0]       m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              mem_chipselect, mem_write, mem_clken, err_oor;
`ifdef ONCHIP_MEM_ARB_LOCK_EN
    logic              m0_lock, m1_lock;
`endif

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
`ifdef ONCHIP_MEM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .err_oor(err_oor)
    );

    // RAM the arbiter drives: synchronous, registered read, byte-lane writes
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    int errors = 0;
    int checks = 0;

    // Reference model: expected contents, who was served last, the read due back
    logic [31:0] model_mem [0:(1<<ADDR_W)-1];
    int          prev_served;
    bit          ret_valid;
    int          ret_owner;
    logic [31:0] ret_data;
    bit          model_err;

    int          exp_winner;
    bit          exp_w0, exp_w1, exp_cs, exp_mw, exp_rv0, exp_rv1, exp_err;
    logic [31:0] exp_rd0, exp_rd1;
    logic [14:0] exp_addr;

    task automatic predict();
        bit r0, r1, wr;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (reset)          exp_winner = -1;
        else if (r0 && r1)  exp_winner = (prev_served == 0) ? 1 : 0;
        else if (r0)        exp_winner = 0;
        else if (r1)        exp_winner = 1;
        else                exp_winner = -1;
        exp_w0   = (exp_winner != 0);
        exp_w1   = (exp_winner != 1);
        exp_addr = (exp_winner == 1) ? m1_address : m0_address;
        wr       = (exp_winner == 1) ? m1_write : m0_write;
        exp_cs   = (exp_winner >= 0) && (int'(exp_addr) < DEPTH);
        exp_mw   = exp_cs && wr;
        exp_rv0  = !reset && ret_valid && ret_owner == 0;
        exp_rv1  = !reset && ret_valid && ret_owner == 1;
        exp_rd0  = exp_rv0 ? ret_data : 32'h0;
        exp_rd1  = exp_rv1 ? ret_data : 32'h0;
        exp_err  = !reset && model_err;
    endtask

    task automatic commit();
        logic [14:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          wr;
        ret_valid = 0;
        if (reset) begin
            prev_served = 1;
            model_err   = 0;
        end else if (exp_winner >= 0) begin
            a  = (exp_winner == 1) ? m1_address    : m0_address;
            be = (exp_winner == 1) ? m1_byteenable : m0_byteenable;
            wd = (exp_winner == 1) ? m1_writedata  : m0_writedata;
            wr = (exp_winner == 1) ? m1_write      : m0_write;
            if (wr) begin
                if (int'(a) < DEPTH)
                    for (int b = 0; b < 4; b++) if (be[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
            end else begin
                ret_valid = 1;
                ret_owner = exp_winner;
                ret_data  = (int'(a) < DEPTH) ? model_mem[a] : 32'h0;
            end
            if (int'(a) >= DEPTH) model_err = 1;
            prev_served = exp_winner;
        end
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic drive0(bit rd, bit wr, logic [14:0] a, logic [3:0] be, logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic drive1(bit rd, bit wr, logic [14:0] a, logic [3:0] be, logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic idle_all();
        drive0(0, 0, 15'd0, 4'h0, 32'h0);
        drive1(0, 0, 15'd0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1;
        idle_all();
        tick();
        tick();
        drive0(1, 0, 15'd3, 4'hF, 32'h0);
        drive1(0, 1, 15'd4, 4'hF, 32'h12345678);
        settle();
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0: got %b want 1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait1: got %b want 1", m1_waitrequest); end
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b%b want 00", m1_readdatavalid, m0_readdatavalid); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL reset_clken: got %b want 0", mem_clken); end
        checks++; if (mem_address !== 15'd0 || mem_byteenable !== 4'h0 || mem_writedata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h/%h want zeros", mem_address, mem_byteenable, mem_writedata); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_oor); end
        tick();
        reset = 0;
        idle_all();
        settle();
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL post_reset_clken: got %b want 1", mem_clken); end
        checks++; if (mem_chipselect !== 1'b0 || mem_address !== 15'd0) begin errors++; $display("FAIL idle_hold: cs=%b addr=%h want 0/0", mem_chipselect, mem_address); end
        tick();
    endtask

    task automatic test_write_read();
        drive0(0, 1, 15'd5, 4'hF, 32'hDEADBEEF);
        settle();
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_accept: wait0 got %b want 0", m0_waitrequest); end
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_issue: cs=%b we=%b want 1/1", mem_chipselect, mem_write); end
        checks++; if (mem_address !== 15'd5 || mem_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: addr=%h data=%h want 5/deadbeef", mem_address, mem_writedata); end
        tick();
        drive0(1, 0, 15'd5, 4'hF, 32'h0);
        settle();
        checks++; if (m0_waitrequest !== 1'b0 || mem_write !== 1'b0 || mem_chipselect !== 1'b1) begin errors++; $display("FAIL rd_accept: wait0=%b we=%b cs=%b want 0/0/1", m0_waitrequest, mem_write, mem_chipselect); end
        checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin errors++; $display("FAIL rd_early: rdv=%b data=%h want 0/0", m0_readdatavalid, m0_readdata); end
        tick();
        idle_all();
        settle();
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_return: rdv=%b data=%h want 1/deadbeef", m0_readdatavalid, m0_readdata); end
        checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_other: rdv1=%b want 0", m1_readdatavalid); end
        tick();
    endtask

    task automatic test_round_robin();
        int g, pg;
        reset = 1;
        idle_all();
        tick();
        reset = 0;
        drive0(1, 0, 15'd5, 4'hF, 32'h0);
        drive1(1, 0, 15'd5, 4'hF, 32'h0);
        pg = -1;
        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            settle();
            checks++; if (m0_waitrequest !== (g != 0) || m1_waitrequest !== (g != 1)) begin errors++; $display("FAIL rr_grant cyc%0d: wait=%b%b want %b%b", k, m1_waitrequest, m0_waitrequest, g != 1, g != 0); end
            checks++; if (m0_readdatavalid !== (pg == 0) || m1_readdatavalid !== (pg == 1)) begin errors++; $display("FAIL rr_rdv cyc%0d: rdv=%b%b want %b%b", k, m1_readdatavalid, m0_readdatavalid, pg == 1, pg == 0); end
            checks++; if ((m0_readdata | m1_readdata) !== ((pg >= 0) ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL rr_data cyc%0d: got %h/%h", k, m0_readdata, m1_readdata); end
            tick();
            pg = g;
        end
        idle_all();
        tick();
    endtask

    task automatic test_partial_write();
        drive1(0, 1, 15'd7, 4'hF, 32'hAAAAAAAA);
        tick();
        drive1(0, 1, 15'd7, 4'h3, 32'h11223344);
        settle();
        checks++; if (m1_waitrequest !== 1'b0 || mem_byteenable !== 4'h3) begin errors++; $display("FAIL pw_issue: wait1=%b be=%h want 0/3", m1_waitrequest, mem_byteenable); end
        tick();
        drive1(1, 0, 15'd7, 4'hF, 32'h0);
        tick();
        idle_all();
        settle();
        checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hAAAA3344) begin errors++; $display("FAIL pw_read: rdv=%b data=%h want 1/aaaa3344", m1_readdatavalid, m1_readdata); end
        tick();
    endtask

    task automatic test_out_of_range();
        drive0(1, 0, 15'd25000, 4'hF, 32'h0);
        settle();
        checks++; if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL oor_accept: wait0=%b cs=%b want 0/0", m0_waitrequest, mem_chipselect); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_err_early: got %b want 0", err_oor); end
        tick();
        drive1(0, 1, 15'd25001, 4'hF, 32'h55555555);
        drive0(0, 0, 15'd0, 4'h0, 32'h0);
        settle();
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin errors++; $display("FAIL oor_return: rdv=%b data=%h want 1/0", m0_readdatavalid, m0_readdata); end
        checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b want 1", err_oor); end
        checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_write_drop: cs=%b we=%b wait1=%b want 0/0/0", mem_chipselect, mem_write, m1_waitrequest); end
        tick();
        idle_all();
        for (int k = 0; k < 3; k++) tick();
        settle();
        checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b want 1", err_oor); end
    endtask

    task automatic test_reset_midop();
        drive0(1, 0, 15'd5, 4'hF, 32'h0);
        tick();
        reset = 1;
        drive0(0, 0, 15'd0, 4'h0, 32'h0);
        drive1(1, 0, 15'd5, 4'hF, 32'h0);
        settle();
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL midrst_rdv: got %b want 0", m0_readdatavalid); end
        checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_wait: got %b%b want 11", m1_waitrequest, m0_waitrequest); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err_oor); end
        tick();
        reset = 0;
        idle_all();
        settle();
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || err_oor !== 1'b0) begin errors++; $display("FAIL postrst: rdv=%b%b err=%b want 00/0", m1_readdatavalid, m0_readdatavalid, err_oor); end
        tick();
    endtask

    task automatic test_random();
        bit          act [2];
        bit          rd [2], wr [2];
        logic [14:0] a [2];
        logic [3:0]  be [2];
        logic [31:0] d [2];
        reset = 1;
        idle_all();
        tick();
        reset = 0;
        for (int m = 0; m < 2; m++) act[m] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 3) != 0) begin
                    act[m] = 1;
                    wr[m]  = $urandom_range(0, 1) == 1;
                    rd[m]  = wr[m] ? ($urandom_range(0, 3) == 0) : 1'b1;
                    a[m]   = ($urandom_range(0, 15) == 0) ? 15'(DEPTH + $urandom_range(0, 100)) : 15'($urandom_range(0, 15));
                    be[m]  = 4'($urandom_range(0, 15));
                    d[m]   = $urandom;
                end
            end
            if (act[0]) drive0(rd[0], wr[0], a[0], be[0], d[0]); else drive0(0, 0, 15'd0, 4'h0, 32'h0);
            if (act[1]) drive1(rd[1], wr[1], a[1], be[1], d[1]); else drive1(0, 0, 15'd0, 4'h0, 32'h0);
            settle();
            checks++; if (m0_waitrequest !== exp_w0 || m1_waitrequest !== exp_w1) begin errors++; $display("FAIL rnd_wait cyc%0d: got %b%b want %b%b", cyc, m1_waitrequest, m0_waitrequest, exp_w1, exp_w0); end
            checks++; if (mem_chipselect !== exp_cs || mem_write !== exp_mw) begin errors++; $display("FAIL rnd_issue cyc%0d: cs=%b we=%b want %b/%b", cyc, mem_chipselect, mem_write, exp_cs, exp_mw); end
            if (exp_cs) begin
                checks++; if (mem_address !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, mem_address, exp_addr); end
            end
            checks++; if (m0_readdatavalid !== exp_rv0 || m0_readdata !== exp_rd0) begin errors++; $display("FAIL rnd_m0_read cyc%0d: rdv=%b data=%h want %b/%h", cyc, m0_readdatavalid, m0_readdata, exp_rv0, exp_rd0); end
            checks++; if (m1_readdatavalid !== exp_rv1 || m1_readdata !== exp_rd1) begin errors++; $display("FAIL rnd_m1_read cyc%0d: rdv=%b data=%h want %b/%h", cyc, m1_readdatavalid, m1_readdata, exp_rv1, exp_rd1); end
            checks++; if (err_oor !== exp_err) begin errors++; $display("FAIL rnd_err cyc%0d: got %b want %b", cyc, err_oor, exp_err); end
            if (exp_winner >= 0) act[exp_winner] = 0;
            tick();
        end
        idle_all();
        tick();
    endtask

`ifdef ONCHIP_MEM_ARB_LOCK_EN
    task automatic test_lock();
        reset = 1;
        idle_all();
        m0_lock = 0;
        m1_lock = 0;
        tick();
        reset = 0;
        drive1(1, 0, 15'd5, 4'hF, 32'h0);
        m1_lock = 1;
        settle();
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL lock_accept: wait1=%b want 0", m1_waitrequest); end
        tick();
        drive1(0, 0, 15'd0, 4'h0, 32'h0);
        drive0(1, 0, 15'd5, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (m0_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL lock_hold cyc%0d: wait0=%b cs=%b want 1/0", k, m0_waitrequest, mem_chipselect); end
            tick();
        end
        m1_lock = 0;
        settle();
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL lock_drop_cycle: wait0=%b want 1", m0_waitrequest); end
        tick();
        settle();
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL lock_release: wait0=%b want 0", m0_waitrequest); end
        tick();
        idle_all();
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end
        prev_served = 1;
        ret_valid   = 0;
        ret_owner   = 0;
        ret_data    = 32'h0;
        model_err   = 0;
        reset       = 1;
        idle_all();
`ifdef ONCHIP_MEM_ARB_LOCK_EN
        m0_lock = 0;
        m1_lock = 0;
`endif
        @(negedge clk);
        test_reset();
        test_write_read();
        test_round_robin();
        test_partial_write();
        test_out_of_range();
        test_reset_midop();
        test_random();
`ifdef ONCHIP_MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master arbiter that shares the single-port 32-bit on-chip RAM between master 0 (Nios II data port) and master 1 (DMA/streaming engine).
- Uses Avalon-MM pipelined semantics on the master side: waitrequest, readdatavalid and a fixed 1-cycle read latency.
- On the memory side, drives the RAM's address, byteenable, chipselect, write and clken inputs.
- Sits between the system interconnect and the on-chip memory instance; also flags out-of-range accesses.

Parameters:
- ADDR_W, 15, word-address width of the masters and the RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 25000, number of implemented words; word addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  master N word address (N = 0, 1)
- mN_byteenable  in  DATA_W/8  master N byte lanes
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_W  master N write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data returned to master N
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable; tied high except during reset
- mem_readdata  in  DATA_W  RAM output; valid 1 cycle after a read is issued
- err_oor  out  1  sticky out-of-range flag; cleared only by reset

Behaviour:
- Request: reqN = mN_read | mN_write. If read and write are both high, treat the request as a write.
- Grant is combinational from reqN and the registered last_grant:
  - Only one master requesting: that master is granted.
  - Both requesting: the master != last_grant is granted (round-robin).
  - last_grant updates on every accept.
- Accept: in the grant cycle, the granted master's waitrequest = 0. Every non-granted or idle master sees waitrequest = 1.
  - A master must hold address, data and command stable until accepted.
- Issue: in the accept cycle, the granted master's address, byteenable and writedata are muxed onto the mem_* outputs, with mem_chipselect = 1 and mem_write = write.
  - With no grant: mem_chipselect = 0, mem_write = 0, and address/data hold their last value.
- Read return:
  - A 1-bit pending register and an owner register capture each accepted read.
  - Next cycle: mN_readdatavalid = 1 for the owner only, and mN_readdata = mem_readdata.
  - Throughput is one access per cycle; back-to-back reads from either master are allowed.
- Out of range (address >= DEPTH):
  - The access is still accepted, but mem_chipselect = 0 so nothing reaches the RAM.
  - A write is dropped.
  - A read returns readdata = 0 with readdatavalid asserted on the normal schedule.
  - err_oor is set on the cycle after the accept.
- mN_readdata is 0 whenever mN_readdatavalid = 0.
- Reset values:
  - waitrequest = 1 for both masters during reset; readdatavalid = 0.
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0.
  - mem_address/mem_byteenable/mem_writedata = 0.
  - last_grant = 1, so master 0 wins the first contention. pending = 0; err_oor = 0.
- Reset mid-operation: an in-flight read is discarded and no readdatavalid is produced after reset. There is no pending state beyond one cycle.
- A simultaneous accept and readdatavalid to the same master is legal and required.

Optional Feature:
- ONCHIP_MEM_ARB_LOCK_EN
- Defined:
  - Adds inputs m0_lock and m1_lock.
  - If a master is accepted with lock = 1, the grant is pinned to it: the other master sees waitrequest = 1 regardless of round-robin.
  - The pin releases on the first cycle in which the pinned master's lock = 0, or on reset.
  - While pinned and the locked master is idle, no access is issued.
- Undefined: no lock ports; pure round-robin as above.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to address 5 with byteenable 0xF, then reads address 5 -> m0_waitrequest = 0 in both cycles; m0_readdatavalid = 1 with 0xDEADBEEF exactly one cycle after the read accept.
- m0 and m1 both read continuously from reset -> grants alternate m0, m1, m0, m1; each master's readdatavalid pulses every other cycle with the correct data; the other master's waitrequest = 1 in between.
- m1 writes 0x11223344 to address 7 with byteenable 0x3 over preset 0xAAAAAAAA -> a subsequent read returns 0xAAAA3344.
- m0 reads address 25000 -> mem_chipselect = 0; m0_readdata = 0 and readdatavalid = 1 one cycle later; err_oor = 1 and stays 1 until reset.
- m0 read accepted, reset asserted the next cycle -> no readdatavalid; both waitrequest = 1 and err_oor = 0 during reset.
- With ONCHIP_MEM_ARB_LOCK_EN: m1 is accepted with lock = 1 while m0 requests for 4 cycles -> m0_waitrequest = 1 throughout; m0 is accepted on the cycle after m1 drops lock.
